// File: rtl/lsu_axi_pkg.sv
// Shared encodings for the LSU-to-AXI4-Lite master: access sizes, AXI response codes,
// FSM states and the latched request fields needed after accept.
package lsu_axi_pkg;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] EXOKAY = 2'd1;
  localparam logic [1:0] SLVERR = 2'd2;
  localparam logic [1:0] DECERR = 2'd3;

  typedef enum logic [2:0] {IDLE, AR, R, WR, B, RESP} state_t;

  // Only what load extraction needs once the address has gone to the bus.
  typedef struct packed {
    logic [1:0] off;
    logic [1:0] size;
    logic       uns;
  } ld_req_t;
endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store data/strobe placement and load
// extraction with sign/zero extension.
module lsu_lane_align
  import lsu_axi_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_LANES = DATA_W / 8
) (
  input  logic [1:0]           st_off,
  input  logic [1:0]           st_size,
  input  logic [DATA_W-1:0]    st_data,
  output logic [DATA_W-1:0]    st_wdata,
  output logic [NUM_LANES-1:0] st_wstrb,
  input  logic [1:0]           ld_off,
  input  logic [1:0]           ld_size,
  input  logic                 ld_uns,
  input  logic [DATA_W-1:0]    ld_data,
  output logic [DATA_W-1:0]    ld_ext
);
  logic [DATA_W-1:0] sh;

  always_comb begin
    st_wdata = st_data << {st_off, 3'b000};
    // Strobes shifted past the top lane are dropped by the 4-bit width.
    case (st_size)
      SZ_B:    st_wstrb = NUM_LANES'(4'b0001) << st_off;
      SZ_H:    st_wstrb = NUM_LANES'(4'b0011) << st_off;
      default: st_wstrb = '1;
    endcase

    sh = ld_data >> {ld_off, 3'b000};
    case (ld_size)
      SZ_B:    ld_ext = {{(DATA_W-8){~ld_uns & sh[7]}}, sh[7:0]};
      SZ_H:    ld_ext = {{(DATA_W-16){~ld_uns & sh[15]}}, sh[15:0]};
      default: ld_ext = sh;
    endcase
  end
endmodule

// File: rtl/lsu_axi_master.sv
// LSU request to AXI4-Lite master bridge, one outstanding access at a time.
// Optional LSU_AXI_MISALIGN_CHECK_EN rejects misaligned half/word accesses without bus traffic.
module lsu_axi_master
  import lsu_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  output logic                rready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  output logic                bready,
  input  logic [1:0]          bresp,
  input  logic                bvalid
);
  state_t            state, state_nxt;
  ld_req_t           rq;
  logic              aw_done, w_done;
  logic              accept, bad;
  logic [DATA_W-1:0] st_wdata, ld_ext;
  logic [DATA_W/8-1:0] st_wstrb;

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .st_off  (req_addr[1:0]),
    .st_size (req_size),
    .st_data (req_wdata),
    .st_wdata(st_wdata),
    .st_wstrb(st_wstrb),
    .ld_off  (rq.off),
    .ld_size (rq.size),
    .ld_uns  (rq.uns),
    .ld_data (rdata),
    .ld_ext  (ld_ext)
  );

  assign accept = req_valid && req_ready;

  always_comb begin
    bad = (req_size == 2'd3);
`ifdef LSU_AXI_MISALIGN_CHECK_EN
    bad = bad || (req_size == SZ_H && req_addr[0]) || (req_size == SZ_W && req_addr[1:0] != 2'b00);
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = bad ? RESP : (req_wen ? WR : AR);
      end
      AR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = R;
      end
      R: begin
        rready = 1'b1;
        if (rvalid) state_nxt = RESP;
      end
      WR: begin
        // AW and W retire independently; either may land first or both together.
        awvalid = !aw_done;
        wvalid  = !w_done;
        if ((aw_done || awready) && (w_done || wready)) state_nxt = B;
      end
      B: begin
        bready = 1'b1;
        if (bvalid) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rq         <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      araddr     <= '0;
      awaddr     <= '0;
      wdata      <= '0;
      wstrb      <= '0;
    end else begin
      if (accept) begin
        rq         <= '{off: req_addr[1:0], size: req_size, uns: req_unsigned};
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
        resp_rdata <= '0;
        resp_err   <= bad;
        if (!bad) begin
          if (req_wen) begin
            awaddr <= req_addr;
            wdata  <= st_wdata;
            wstrb  <= st_wstrb;
          end else begin
            araddr <= req_addr;
          end
        end
      end
      if (state == WR) begin
        if (awvalid && awready) aw_done <= 1'b1;
        if (wvalid && wready)   w_done  <= 1'b1;
      end
      if (state == R && rvalid) begin
        resp_rdata <= ld_ext;
        resp_err   <= (rresp != OKAY);
      end
      if (state == B && bvalid) resp_err <= (bresp != OKAY);
    end
  end
endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master with a scripted AXI4-Lite slave.
module tb_lsu_axi_master;
  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic        arvalid, arready, rready, rvalid, awvalid, awready, wvalid, wready, bready, bvalid;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  int vectors = 0, miscompares = 0;

  // Results of the last run_txn
  int          n_ar, n_aw, n_w, n_resp, ar_cyc, resp_cyc;
  logic [31:0] g_rdata, c_araddr, c_awaddr, c_wdata;
  logic [3:0]  c_wstrb;
  logic        g_err;

  lsu_axi_master dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rready(rready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bready(bready), .bresp(bresp), .bvalid(bvalid)
  );

  always #5 clock = ~clock;

  task automatic slave_idle();
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
  endtask

  // Presents one request, then plays a zero-wait slave (AW optionally held) for 12 cycles.
  task automatic run_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] sz, input logic uns, input logic [31:0] rd,
                         input logic [1:0] rsp, input int aw_hold);
    n_ar = 0; n_aw = 0; n_w = 0; n_resp = 0; ar_cyc = -1; resp_cyc = -1;
    g_rdata = 0; g_err = 0; c_araddr = 0; c_awaddr = 0; c_wdata = 0; c_wstrb = 0;
    req_valid = 1; req_wen = wen; req_addr = addr; req_wdata = wd; req_size = sz; req_unsigned = uns;
    @(negedge clock);
    req_valid = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (arvalid) begin n_ar++; c_araddr = araddr; if (ar_cyc < 0) ar_cyc = cyc; end
      arready = arvalid;
      rvalid = rready; rdata = rready ? rd : 32'h0; rresp = rsp;
      if (awvalid) begin n_aw++; c_awaddr = awaddr; end
      awready = awvalid && (n_aw >= aw_hold);
      if (wvalid) begin n_w++; c_wdata = wdata; c_wstrb = wstrb; end
      wready = wvalid;
      bvalid = bready; bresp = rsp;
      if (resp_valid) begin
        n_resp++;
        if (resp_cyc < 0) begin resp_cyc = cyc; g_rdata = resp_rdata; g_err = resp_err; end
      end
      @(negedge clock);
    end
    slave_idle();
  endtask

  task automatic test_reset();
    reset = 1; req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_size = 0; req_unsigned = 0;
    slave_idle();
    repeat (2) @(negedge clock);
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset req_ready got %b want 1", req_ready); end
    vectors++; if ({arvalid, rready, awvalid, wvalid, bready, resp_valid} !== 6'b0) begin miscompares++;
      $display("FAIL reset valids got %b want 000000", {arvalid, rready, awvalid, wvalid, bready, resp_valid}); end
    vectors++; if ({resp_rdata, resp_err} !== 33'h0) begin miscompares++; $display("FAIL reset resp got %h/%b want 0/0", resp_rdata, resp_err); end
    vectors++; if ({araddr, awaddr, wdata, wstrb} !== 100'h0) begin miscompares++;
      $display("FAIL reset bus got %h %h %h %b want zeros", araddr, awaddr, wdata, wstrb); end
    reset = 0;
    @(negedge clock);
  endtask

  task automatic test_load_word();
    run_txn(0, 32'h8000_0004, 0, 2'd2, 0, 32'hDEAD_BEEF, 2'd0, 1);
    vectors++; if (ar_cyc !== 1 || n_ar !== 1) begin miscompares++; $display("FAIL ldw ar got cyc %0d n %0d want 1 1", ar_cyc, n_ar); end
    vectors++; if (c_araddr !== 32'h8000_0004) begin miscompares++; $display("FAIL ldw araddr got %h want 80000004", c_araddr); end
    vectors++; if (resp_cyc !== 3 || n_resp !== 1) begin miscompares++; $display("FAIL ldw resp got cyc %0d n %0d want 3 1", resp_cyc, n_resp); end
    vectors++; if (g_rdata !== 32'hDEAD_BEEF || g_err !== 1'b0) begin miscompares++; $display("FAIL ldw data got %h/%b want deadbeef/0", g_rdata, g_err); end
    run_txn(0, 32'h8000_0000, 0, 2'd2, 1, 32'h8765_4321, 2'd0, 1);
    vectors++; if (g_rdata !== 32'h8765_4321) begin miscompares++; $display("FAIL ldw_uns got %h want 87654321", g_rdata); end
  endtask

  task automatic test_load_subword();
    run_txn(0, 32'h8000_0003, 0, 2'd0, 0, 32'h8012_3456, 2'd0, 1);
    vectors++; if (g_rdata !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL ldb_s got %h want ffffff80", g_rdata); end
    vectors++; if (c_araddr !== 32'h8000_0003) begin miscompares++; $display("FAIL ldb araddr got %h want 80000003", c_araddr); end
    run_txn(0, 32'h8000_0003, 0, 2'd0, 1, 32'h8012_3456, 2'd0, 1);
    vectors++; if (g_rdata !== 32'h0000_0080) begin miscompares++; $display("FAIL ldb_u got %h want 00000080", g_rdata); end
    run_txn(0, 32'h8000_0002, 0, 2'd1, 0, 32'hF00D_1234, 2'd0, 1);
    vectors++; if (g_rdata !== 32'hFFFF_F00D) begin miscompares++; $display("FAIL ldh_s got %h want fffff00d", g_rdata); end
    run_txn(0, 32'h8000_0002, 0, 2'd1, 1, 32'hF00D_1234, 2'd0, 1);
    vectors++; if (g_rdata !== 32'h0000_F00D) begin miscompares++; $display("FAIL ldh_u got %h want 0000f00d", g_rdata); end
  endtask

  task automatic test_store();
    run_txn(1, 32'h8000_0002, 32'h0000_ABCD, 2'd1, 0, 0, 2'd0, 3);
    vectors++; if (c_wdata !== 32'hABCD_0000 || c_wstrb !== 4'b1100) begin miscompares++;
      $display("FAIL sth lanes got %h/%b want abcd0000/1100", c_wdata, c_wstrb); end
    vectors++; if (c_awaddr !== 32'h8000_0002) begin miscompares++; $display("FAIL sth awaddr got %h want 80000002", c_awaddr); end
    vectors++; if (n_w !== 1 || n_aw !== 3) begin miscompares++; $display("FAIL sth hold got w %0d aw %0d want 1 3", n_w, n_aw); end
    vectors++; if (n_resp !== 1 || resp_cyc !== 5) begin miscompares++; $display("FAIL sth resp got n %0d cyc %0d want 1 5", n_resp, resp_cyc); end
    vectors++; if (g_rdata !== 32'h0 || g_err !== 1'b0 || n_ar !== 0) begin miscompares++;
      $display("FAIL sth result got %h/%b ar %0d want 0/0 0", g_rdata, g_err, n_ar); end
    run_txn(1, 32'h8000_0001, 32'h0000_00AB, 2'd0, 0, 0, 2'd0, 1);
    vectors++; if (c_wdata !== 32'h0000_AB00 || c_wstrb !== 4'b0010 || resp_cyc !== 3) begin miscompares++;
      $display("FAIL stb got %h/%b cyc %0d want 0000ab00/0010 3", c_wdata, c_wstrb, resp_cyc); end
  endtask

  task automatic test_errors();
    run_txn(0, 32'h0000_0010, 0, 2'd2, 0, 32'h1234_5678, 2'd2, 1);
    vectors++; if (g_err !== 1'b1 || n_resp !== 1) begin miscompares++; $display("FAIL slverr got err %b n %0d want 1 1", g_err, n_resp); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL slverr req_ready got %b want 1", req_ready); end
    run_txn(1, 32'h0000_0020, 32'h5555_AAAA, 2'd2, 0, 0, 2'd3, 1);
    vectors++; if (g_err !== 1'b1 || c_wstrb !== 4'b1111) begin miscompares++; $display("FAIL decerr got err %b strb %b want 1 1111", g_err, c_wstrb); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL decerr req_ready got %b want 1", req_ready); end
    run_txn(0, 32'h8000_0000, 0, 2'd3, 0, 0, 2'd0, 1);
    vectors++; if (g_err !== 1'b1 || n_ar !== 0 || resp_cyc !== 1) begin miscompares++;
      $display("FAIL illegal_ld got err %b ar %0d cyc %0d want 1 0 1", g_err, n_ar, resp_cyc); end
    run_txn(1, 32'h8000_0000, 32'h1, 2'd3, 0, 0, 2'd0, 1);
    vectors++; if (g_err !== 1'b1 || n_aw !== 0 || n_w !== 0) begin miscompares++;
      $display("FAIL illegal_st got err %b aw %0d w %0d want 1 0 0", g_err, n_aw, n_w); end
  endtask

  task automatic test_misalign();
    run_txn(0, 32'h8000_0001, 0, 2'd2, 0, 32'h1122_3344, 2'd0, 1);
`ifdef LSU_AXI_MISALIGN_CHECK_EN
    vectors++; if (g_err !== 1'b1 || n_ar !== 0 || resp_cyc !== 1) begin miscompares++;
      $display("FAIL misalign_chk got err %b ar %0d cyc %0d want 1 0 1", g_err, n_ar, resp_cyc); end
`else
    vectors++; if (n_ar !== 1 || c_araddr !== 32'h8000_0001) begin miscompares++;
      $display("FAIL misalign_nochk got ar %0d addr %h want 1 80000001", n_ar, c_araddr); end
    vectors++; if (g_err !== 1'b0 || g_rdata !== 32'h0011_2233) begin miscompares++;
      $display("FAIL misalign_nochk data got %h/%b want 00112233/0", g_rdata, g_err); end
`endif
  endtask

  task automatic test_reset_midflight();
    int pulses;
    req_valid = 1; req_wen = 0; req_addr = 32'h8000_0000; req_size = 2'd2; req_unsigned = 0;
    @(negedge clock);
    req_valid = 0; arready = 1;
    @(negedge clock);
    arready = 0; rvalid = 0;
    vectors++; if (rready !== 1'b1) begin miscompares++; $display("FAIL midrst in_R got rready %b want 1", rready); end
    reset = 1;
    @(negedge clock);
    reset = 0;
    vectors++; if ({rready, req_ready, resp_valid, arvalid} !== 4'b0100) begin miscompares++;
      $display("FAIL midrst got rready/req_ready/resp/ar %b want 0100", {rready, req_ready, resp_valid, arvalid}); end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid) pulses++;
      @(negedge clock);
    end
    vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL midrst resp pulses got %0d want 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_subword();
    test_store();
    test_errors();
    test_misalign();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
